sd_frame_wr_seq: RTL and testbench

- Multi-sector, multi-slot write sequencer that sits between the frame/capture logic and the SD-card write engine.
- On each frame start it issues one write-enable pulse per sector, SECS_PER_FRAME sectors in total.
- Each sector is handshaked against the engine's wr_busy rise and fall.
- Frames go into a ring of NUM_SLOTS consecutive sector regions starting at BASE_ADDR. It also reports completion, abort, overrun and busy-timeout.

---
 rtl/sd_wr_pkg.sv | 30 +++
 rtl/sd_edge_det.sv | 26 ++
 rtl/sd_frame_wr_seq.sv | 184 ++++++++++++++++++
 tb/tb_sd_frame_wr_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_wr_pkg.sv
// Shared constants for the SD frame write sequencer: one-hot states, default sizes, width helper.
// Latency: none; this package holds only compile-time constants and a constant function.
// Backpressure: none.
package sd_wr_pkg;

    // Default sizing of the sequencer
    localparam int SD_ADDR_W_DEF = 32;
    localparam int SD_SECS_DEF   = 2;
    localparam int SD_SLOTS_DEF  = 4;
    localparam int SD_TMO_DEF    = 1024;

    // One-hot state encoding
    localparam int ST_W = 5;
    localparam logic [ST_W-1:0] ST_IDLE      = 5'b00001;
    localparam logic [ST_W-1:0] ST_ISSUE     = 5'b00010;
    localparam logic [ST_W-1:0] ST_WAIT_BUSY = 5'b00100;
    localparam logic [ST_W-1:0] ST_WAIT_DONE = 5'b01000;
    localparam logic [ST_W-1:0] ST_ERR       = 5'b10000;

    // Ceil(log2(v)), never below 1 so a count of one item still gets a real bit
    function automatic int sd_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sd_edge_det.sv
// Registered edge detector: keeps a one-cycle-delayed copy of a level and flags rise/fall.
// Latency: rise/fall are combinational against the delayed copy, valid in the cycle the level changes.
// Backpressure: none; pure observation of a level.
module sd_edge_det (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_d;

    // Delayed copy of the input level
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;
    assign fall = ~sig & sig_d;

endmodule

// File: rtl/sd_frame_wr_seq.sv
// Frame write sequencer: one wr_en per sector, sectors handshaked on wr_busy rise/fall, frames in a slot ring.
// Latency: frame rise -> wr_en 2 cycles; busy fall -> next wr_en 2 cycles; busy fall -> done/abort 1 cycle.
// Backpressure: the engine throttles via wr_busy; frame edges arriving mid-frame are dropped and flagged.
module sd_frame_wr_seq
    import sd_wr_pkg::*;
#(
    parameter int                ADDR_W         = SD_ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                SECS_PER_FRAME = SD_SECS_DEF,
    parameter int                NUM_SLOTS      = SD_SLOTS_DEF,
    parameter int                BUSY_TMO       = SD_TMO_DEF
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst,
    input  logic                                 frame,
    input  logic                                 wr_busy,
    output logic                                 wr_en,
    output logic [ADDR_W-1:0]                    wr_addr,
    output logic [sd_clog2(NUM_SLOTS)-1:0]       slot_idx,
    output logic [sd_clog2(SECS_PER_FRAME):0]    sec_idx,
    output logic                                 frame_done,
    output logic                                 frame_abort,
    output logic                                 frame_ovr,
    output logic                                 busy_tmo_err
);

    localparam int SLOT_W = sd_clog2(NUM_SLOTS);
    localparam int SEC_W  = sd_clog2(SECS_PER_FRAME) + 1;
    localparam int TMO_W  = sd_clog2(BUSY_TMO);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SEC_W-1:0]  LAST_SEC  = SEC_W'(SECS_PER_FRAME - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(BUSY_TMO - 1);
    localparam logic [ADDR_W-1:0] SLOT_STEP = ADDR_W'(SECS_PER_FRAME);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] slot_base;

    logic frame_rise;
    logic frame_fall_unused;
    logic busy_rise;
    logic busy_fall;

    logic last_sec;
    logic tmo_hit;
    logic in_flight;

    logic start;
    logic next_sec;
    logic wr_en_nxt;
    logic done_nxt;
    logic abort_nxt;
    logic ovr_nxt;
    logic tmo_set;

    sd_edge_det u_frame_edge (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sig     (frame),
        .rise    (frame_rise),
        .fall    (frame_fall_unused)
    );

    sd_edge_det u_busy_edge (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sig     (wr_busy),
        .rise    (busy_rise),
        .fall    (busy_fall)
    );

    assign last_sec  = (sec_idx == LAST_SEC);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign in_flight = (state == ST_ISSUE) || (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; ERR only leaves through reset
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (frame_rise) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy_rise) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_WAIT_DONE: begin
                if (busy_fall) begin
                    if (!last_sec && frame) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output/event decode; the frame-level check is deferred to busy fall so a sector is never cut
    always_comb begin
        start     = (state == ST_IDLE) && frame_rise;
        wr_en_nxt = (state == ST_ISSUE);
        tmo_set   = (state == ST_WAIT_BUSY) && !busy_rise && tmo_hit;
        done_nxt  = (state == ST_WAIT_DONE) && busy_fall && last_sec;
        next_sec  = (state == ST_WAIT_DONE) && busy_fall && !last_sec && frame;
        abort_nxt = (state == ST_WAIT_DONE) && busy_fall && !last_sec && !frame;
        ovr_nxt   = in_flight && frame_rise;
    end

    // Registered outputs, sector/slot bookkeeping and the busy watchdog
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_en        <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            frame_ovr    <= 1'b0;
            busy_tmo_err <= 1'b0;
            wr_addr      <= BASE_ADDR;
            slot_base    <= BASE_ADDR;
            slot_idx     <= '0;
            sec_idx      <= '0;
            tmo_cnt      <= '0;
        end else begin
            wr_en        <= wr_en_nxt;
            frame_done   <= done_nxt;
            frame_abort  <= abort_nxt;
            frame_ovr    <= ovr_nxt;
            busy_tmo_err <= busy_tmo_err | tmo_set;

            if (start) begin
                sec_idx <= '0;
                wr_addr <= slot_base;
            end else if (next_sec) begin
                sec_idx <= sec_idx + SEC_W'(1);
                wr_addr <= wr_addr + ADDR_W'(1);
            end else if (done_nxt || abort_nxt) begin
                sec_idx <= '0;
            end

            // Slot base tracks slot_idx by accumulation instead of a multiply
            if (done_nxt) begin
                if (slot_idx == LAST_SLOT) begin
                    slot_idx  <= '0;
                    slot_base <= BASE_ADDR;
                end else begin
                    slot_idx  <= slot_idx + SLOT_W'(1);
                    slot_base <= slot_base + SLOT_STEP;
                end
            end

            if (state == ST_ISSUE) begin
                tmo_cnt <= '0;
            end else if ((state == ST_WAIT_BUSY) && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sd_frame_wr_seq.sv
module tb_sd_frame_wr_seq;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #10 sys_clk = ~sys_clk;

    // Instance A: default ring, short busy timeout
    logic        frame_a, busy_a;
    logic        wr_en_a, frame_done_a, frame_abort_a, frame_ovr_a, busy_tmo_err_a;
    logic [31:0] wr_addr_a;
    logic [1:0]  slot_idx_a;
    logic [1:0]  sec_idx_a;

    // Instance B: base address at the top of the address space
    logic        frame_b, busy_b;
    logic        wr_en_b, frame_done_b, frame_abort_b, frame_ovr_b, busy_tmo_err_b;
    logic [31:0] wr_addr_b;
    logic [1:0]  slot_idx_b;
    logic [1:0]  sec_idx_b;

    sd_frame_wr_seq #(.ADDR_W(32), .BASE_ADDR(32'h0), .SECS_PER_FRAME(2), .NUM_SLOTS(4), .BUSY_TMO(16)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .frame(frame_a), .wr_busy(busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .slot_idx(slot_idx_a), .sec_idx(sec_idx_a),
        .frame_done(frame_done_a), .frame_abort(frame_abort_a), .frame_ovr(frame_ovr_a),
        .busy_tmo_err(busy_tmo_err_a)
    );

    sd_frame_wr_seq #(.ADDR_W(32), .BASE_ADDR(32'hFFFF_FFFF), .SECS_PER_FRAME(2), .NUM_SLOTS(4), .BUSY_TMO(1024)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .frame(frame_b), .wr_busy(busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .slot_idx(slot_idx_b), .sec_idx(sec_idx_b),
        .frame_done(frame_done_b), .frame_abort(frame_abort_b), .frame_ovr(frame_ovr_b),
        .busy_tmo_err(busy_tmo_err_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_a = 0, abort_a = 0, done_b = 0;
    int fall_cyc_a = 0, fall_cyc_b = 0;
    bit eng_on_a = 1'b1;
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];

    always @(posedge sys_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int cnt(input int sel);
        case (sel)
            0:       return done_a;
            1:       return abort_a;
            default: return done_b;
        endcase
    endfunction

    // Bounded wait for an event counter to reach a target; an expired bound shows as a miscompare
    task automatic wait_cnt(input string tag, input int sel, input int target, input int budget);
        int n;
        n = 0;
        while (cnt(sel) < target && n < budget) begin
            @(posedge sys_clk);
            n++;
        end
        chk(tag, 32'(cnt(sel)), 32'(target));
    endtask

    task automatic wait_busy_a();
        int n;
        n = 0;
        while (!busy_a && n < 50) begin
            @(posedge sys_clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // Write engine model A: 3 cycles after wr_en raise busy for 10 cycles
    initial begin
        busy_a = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (eng_on_a && wr_en_a) begin
                repeat (3) @(negedge sys_clk);
                busy_a = 1'b1;
                repeat (10) @(negedge sys_clk);
                busy_a = 1'b0;
                fall_cyc_a = cyc;
            end
        end
    end

    // Write engine model B
    initial begin
        busy_b = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (wr_en_b) begin
                repeat (3) @(negedge sys_clk);
                busy_b = 1'b1;
                repeat (10) @(negedge sys_clk);
                busy_b = 1'b0;
                fall_cyc_b = cyc;
            end
        end
    end

    // Scoreboard side: every wr_en pops the expected address; done/abort timing checked against busy fall
    initial begin
        forever begin
            @(negedge sys_clk);
            if (wr_en_a) begin
                if (exp_q_a.size() == 0) chk("a_wr_en_unexpected", 32'(wr_en_a), 32'd0);
                else chk("a_wr_addr", wr_addr_a, exp_q_a.pop_front());
            end
            if (frame_done_a) begin
                done_a++;
                chk("a_done_latency", 32'(cyc), 32'(fall_cyc_a + 1));
            end
            if (frame_abort_a) begin
                abort_a++;
                chk("a_abort_latency", 32'(cyc), 32'(fall_cyc_a + 1));
            end
            if (wr_en_b) begin
                if (exp_q_b.size() == 0) chk("b_wr_en_unexpected", 32'(wr_en_b), 32'd0);
                else chk("b_wr_addr", wr_addr_b, exp_q_b.pop_front());
            end
            if (frame_done_b) begin
                done_b++;
                chk("b_done_latency", 32'(cyc), 32'(fall_cyc_b + 1));
            end
        end
    end

    initial begin
        int n;
        int exp_done;
        int s;
        sys_rst = 1'b1;
        frame_a = 1'b0;
        frame_b = 1'b0;

        // Reset state
        do_reset();
        chk("rst_wr_en", 32'(wr_en_a), 32'd0);
        chk("rst_wr_addr", wr_addr_a, 32'h0);
        chk("rst_slot", 32'(slot_idx_a), 32'd0);
        chk("rst_sec", 32'(sec_idx_a), 32'd0);
        chk("rst_done", 32'(frame_done_a), 32'd0);
        chk("rst_abort", 32'(frame_abort_a), 32'd0);
        chk("rst_ovr", 32'(frame_ovr_a), 32'd0);
        chk("rst_err", 32'(busy_tmo_err_a), 32'd0);
        chk("rst_b_wr_addr", wr_addr_b, 32'hFFFF_FFFF);

        // Single frame: two sectors, addresses 0 and 1, slot advances to 1
        exp_q_a.push_back(32'd0);
        exp_q_a.push_back(32'd1);
        frame_a = 1'b1;
        @(negedge sys_clk);
        chk("t1_wr_en_early", 32'(wr_en_a), 32'd0);
        @(negedge sys_clk);
        chk("t1_rise_to_wr_en", 32'(wr_en_a), 32'd1);
        chk("t1_sec0", 32'(sec_idx_a), 32'd0);
        wait_cnt("t1_done", 0, 1, 200);
        chk("t1_slot", 32'(slot_idx_a), 32'd1);
        @(negedge sys_clk);
        frame_a = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("t1_done_once", 32'(done_a), 32'd1);

        // Ring: five frames from slot 0, slot wraps 3 -> 0
        do_reset();
        exp_done = done_a;
        for (int f = 0; f < 5; f++) begin
            s = f % 4;
            exp_q_a.push_back(32'(2 * s));
            exp_q_a.push_back(32'(2 * s + 1));
            frame_a = 1'b1;
            exp_done++;
            wait_cnt("t2_done", 0, exp_done, 200);
            chk("t2_slot", 32'(slot_idx_a), 32'((f + 1) % 4));
            @(negedge sys_clk);
            frame_a = 1'b0;
            repeat (2) @(negedge sys_clk);
        end

        // Abort: frame falls during the first sector's busy
        do_reset();
        exp_done = done_a;
        exp_q_a.push_back(32'd0);
        frame_a = 1'b1;
        wait_busy_a();
        @(negedge sys_clk);
        frame_a = 1'b0;
        wait_cnt("t3_abort", 1, 1, 100);
        chk("t3_slot_kept", 32'(slot_idx_a), 32'd0);
        repeat (8) @(negedge sys_clk);
        chk("t3_no_done", 32'(done_a), 32'(exp_done));
        exp_q_a.push_back(32'd0);
        exp_q_a.push_back(32'd1);
        frame_a = 1'b1;
        exp_done++;
        wait_cnt("t3_restart_done", 0, exp_done, 200);
        chk("t3_restart_slot", 32'(slot_idx_a), 32'd1);
        @(negedge sys_clk);
        frame_a = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Overrun: a second rising edge while the first sector is in WAIT_DONE
        do_reset();
        exp_q_a.push_back(32'd0);
        exp_q_a.push_back(32'd1);
        frame_a = 1'b1;
        wait_busy_a();
        @(negedge sys_clk);
        frame_a = 1'b0;
        @(negedge sys_clk);
        frame_a = 1'b1;
        @(negedge sys_clk);
        chk("t4_ovr_pulse", 32'(frame_ovr_a), 32'd1);
        @(negedge sys_clk);
        chk("t4_ovr_cleared", 32'(frame_ovr_a), 32'd0);
        exp_done++;
        wait_cnt("t4_done", 0, exp_done, 200);
        @(negedge sys_clk);
        frame_a = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("t4_done_once", 32'(done_a), 32'(exp_done));
        chk("t4_no_abort", 32'(abort_a), 32'd1);

        // Busy timeout: engine silent, error 16 cycles after wr_en, then absorbing
        do_reset();
        eng_on_a = 1'b0;
        exp_q_a.push_back(32'd0);
        frame_a = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!wr_en_a && n < 10);
        chk("t5_wr_en_seen", 32'(wr_en_a), 32'd1);
        repeat (15) @(negedge sys_clk);
        chk("t5_err_not_yet", 32'(busy_tmo_err_a), 32'd0);
        @(negedge sys_clk);
        chk("t5_err_set", 32'(busy_tmo_err_a), 32'd1);
        for (int k = 0; k < 3; k++) begin
            frame_a = 1'b0;
            repeat (2) @(negedge sys_clk);
            frame_a = 1'b1;
            repeat (4) @(negedge sys_clk);
            chk("t5_err_ovr", 32'(frame_ovr_a), 32'd0);
        end
        chk("t5_err_sticky", 32'(busy_tmo_err_a), 32'd1);
        frame_a = 1'b0;
        do_reset();
        chk("t5_rst_err", 32'(busy_tmo_err_a), 32'd0);
        chk("t5_rst_wr_en", 32'(wr_en_a), 32'd0);
        chk("t5_rst_addr", wr_addr_a, 32'h0);
        eng_on_a = 1'b1;

        // Address wrap at the top of the address space
        exp_q_b.push_back(32'hFFFF_FFFF);
        exp_q_b.push_back(32'h0000_0000);
        frame_b = 1'b1;
        wait_cnt("t6_done", 2, 1, 200);
        chk("t6_slot", 32'(slot_idx_b), 32'd1);
        @(negedge sys_clk);
        frame_b = 1'b0;
        repeat (5) @(negedge sys_clk);

        chk("end_q_a_empty", 32'(exp_q_a.size()), 32'd0);
        chk("end_q_b_empty", 32'(exp_q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
